// File: rtl/acc_display_pkg.sv
// acc_display_pkg
//   Shared definitions for the accumulator BCD display stage: the converter
//   FSM state encoding and the active-low 7-segment patterns ({g,f,e,d,c,b,a},
//   0 = segment lit).
package acc_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7
//   Combinational BCD nibble to active-low 7-segment decoder.
//   Ports:
//     nibble_i  BCD digit (values above 9 decode to blank)
//     blank_i   force the display dark
//     seg_o     active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg7
  import acc_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (nibble_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/acc_bcd_display.sv
// acc_bcd_display
//   Captures the 8-bit accumulator result plus its carry bit as one unsigned
//   operand, converts it to BCD with a one-bit-per-clock shift-add-3 sequence
//   and registers the decoded digits onto three active-low 7-seg displays,
//   optionally blanking leading zeros. Displays hold between conversions.
//   Ports:
//     clk          rising-edge clock
//     reset        synchronous active-high reset
//     start        conversion request, honoured only while idle
//     value, ovf   operand {ovf, value}, sampled on the accepting edge
//     busy         conversion in progress (SHIFT or LATCH)
//     done         one-cycle pulse following the display update
//     HEX0..HEX2   units / tens / hundreds segments, active-low
module acc_bcd_display #(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned DIGITS   = 3,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] value,
  input  logic       ovf,
  output logic       busy,
  output logic       done,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2
);

  import acc_display_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned BCD_W = 4 * DIGITS;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d, bcd_adj;
  logic [WIDTH-1:0]         op_q, op_d;
  logic [BCD_W+WIDTH-1:0]   shift_w;
  logic                     done_q, done_d;
  logic [6:0]               hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d;

  logic [DIGITS-1:0]        blank_w;
  logic [6:0]               seg_w [DIGITS];

  // Shift-add-3 correction: any nibble >= 5 would reach >= 10 after the
  // doubling, so pre-add 3 to carry it into the next decade.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shift_w = {bcd_adj, op_q} << 1;

  // A digit is blanked when it and every more-significant digit are zero;
  // the units digit always shows.
  always_comb begin
    logic higher_zero;
    int unsigned d;
    higher_zero = 1'b1;
    blank_w     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d           = DIGITS - 1 - i;
      higher_zero = higher_zero & (bcd_q[4*d +: 4] == 4'd0);
      blank_w[d]  = BLANK_LZ & higher_zero & (d != 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_to_seg7 u_seg (
      .nibble_i (bcd_q[4*g +: 4]),
      .blank_i  (blank_w[g]),
      .seg_o    (seg_w[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    op_d    = op_q;
    done_d  = 1'b0;
    hex0_d  = hex0_q;
    hex1_d  = hex1_q;
    hex2_d  = hex2_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = WIDTH'({ovf, value});
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = shift_w[BCD_W+WIDTH-1:WIDTH];
        op_d  = shift_w[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        hex0_d  = seg_w[0];
        hex1_d  = seg_w[1];
        hex2_d  = seg_w[2];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
      hex0_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      op_q    <= op_d;
      done_q  <= done_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;

endmodule

// File: tb/tb_acc_bcd_display.sv
// tb_acc_bcd_display
//   Directed bench for acc_bcd_display with hand-computed segment patterns.
module tb_acc_bcd_display;

  localparam logic [6:0] BLK = 7'h7F;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;

  logic       clk = 1'b0;
  logic       reset, start, ovf, busy, done;
  logic [7:0] value;
  logic [6:0] HEX0, HEX1, HEX2;

  int tests_run = 0;
  int tests_failed = 0;

  acc_bcd_display #(.WIDTH(9), .DIGITS(3), .BLANK_LZ(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (value),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] e2, input logic [6:0] e1,
                           input logic [6:0] e0);
    check_eq({tag, " HEX2"}, 32'(HEX2), 32'(e2));
    check_eq({tag, " HEX1"}, 32'(HEX1), 32'(e1));
    check_eq({tag, " HEX0"}, 32'(HEX0), 32'(e0));
  endtask

  // One full conversion: start accepted at edge k, done expected after edge k+10.
  task automatic run_conv(input string tag, input logic [7:0] v, input logic o,
                          input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] p2, p1, p0;
    int n;
    bit seen;
    @(negedge clk);
    p2 = HEX2; p1 = HEX1; p0 = HEX0;
    value = v; ovf = o; start = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, " busy@accept"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0; value = ~v; ovf = ~o;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
      else if (n == 9) begin
        check_eq({tag, " busy@k+9"}, 32'(busy), 32'd1);
        check_hex({tag, " hold"}, p2, p1, p0);
      end
    end
    check_eq({tag, " latency"}, 32'(n), 32'd10);
    check_eq({tag, " busy@done"}, 32'(busy), 32'd0);
    check_hex(tag, e2, e1, e0);
    @(posedge clk); #1;
    check_eq({tag, " done width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones, first, second;
    reset = 1'b1; start = 1'b0; value = '0; ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_hex("reset", BLK, BLK, BLK);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    @(negedge clk); reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (busy || done || HEX0 != BLK || HEX1 != BLK || HEX2 != BLK) dones++;
    end
    check_eq("idle quiet", 32'(dones), 32'd0);

    run_conv("zero",  8'd0,   1'b0, BLK, BLK, S0);
    run_conv("510",   8'd254, 1'b1, S5,  S1,  S0);
    run_conv("7",     8'd7,   1'b0, BLK, BLK, S7);
    run_conv("205",   8'd205, 1'b0, S2,  S0,  S5);
    run_conv("123",   8'd123, 1'b0, S1,  S2,  S3);
    run_conv("256",   8'd0,   1'b1, S2,  S5,  7'b0000010);

    // Busy rejection: second start (value 17) at cycle 4 must be ignored.
    @(negedge clk);
    value = 8'd255; ovf = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    dones = 0; first = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      start = (n == 4);
      value = (n >= 4) ? 8'd17 : 8'd0;
      @(posedge clk); #1;
      if (done) begin dones++; if (first == 0) first = n; end
    end
    check_eq("busy-rej dones", 32'(dones), 32'd1);
    check_eq("busy-rej latency", 32'(first), 32'd10);
    check_hex("busy-rej", S2, S5, S5);

    // Reset mid-conversion at edge k+5.
    @(negedge clk);
    value = 8'd123; ovf = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    dones = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      reset = (n == 5);
      @(posedge clk); #1;
      if (done) dones++;
      if (n == 4) check_hex("pre-reset hold", S2, S5, S5);
      if (n == 5) begin
        check_eq("mid-reset busy", 32'(busy), 32'd0);
        check_hex("mid-reset", BLK, BLK, BLK);
      end
    end
    check_eq("mid-reset no done", 32'(dones), 32'd0);

    // Reset and start together: reset wins.
    @(negedge clk); reset = 1'b1; start = 1'b1; value = 8'd9;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_eq("reset+start busy", 32'(busy), 32'd0);

    // Start held high: conversions every 11 cycles.
    @(negedge clk); value = 8'd42; ovf = 1'b0; start = 1'b1;
    dones = 0; first = 0; second = 0;
    for (int n = 0; n <= 21; n++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first == 0) first = n; else second = n;
      end
    end
    @(negedge clk); start = 1'b0;
    check_eq("held dones", 32'(dones), 32'd2);
    check_eq("held first", 32'(first), 32'd10);
    check_eq("held second", 32'(second), 32'd21);
    check_hex("held", BLK, S4, S2);
    repeat (12) @(posedge clk);
    #1;
    check_eq("held idle busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
